// File: rtl/reset_gen_pkg.sv
// Shared types for the system reset generator: FSM states, reset causes and
// synchroniser idle levels.
package reset_gen_pkg;

    typedef enum logic [1:0] {
        STRETCH = 2'd0,
        RUN     = 2'd1,
        HELD    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_BTN  = 2'd1,
        CAUSE_TRAP = 2'd2
    } cause_t;

    localparam logic BTN_IDLE  = 1'b1;
    localparam logic TRAP_IDLE = 1'b0;

    // Every state except RUN keeps the core in reset.
    function automatic logic state_holds_reset(input state_t st);
        return (st != RUN);
    endfunction

endpackage

// File: rtl/reset_gen_debounce.sv
// Two-flop synchroniser plus debounce counter for the board reset button.
// btn_pressed toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce
    import reset_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic btn_pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic          btn_meta_r;
    logic          btn_sync_r;
    logic          level_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic          pressed_r;
    logic          pressed_nx_s;

    // Synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_r <= BTN_IDLE;
            btn_sync_r <= BTN_IDLE;
        end else begin
            btn_meta_r <= btn_n;
            btn_sync_r <= btn_meta_r;
        end
    end

    assign level_s = ~btn_sync_r;

    // Debounce decision: count disagreement, toggle on the final count.
    always_comb begin
        cnt_nx_s     = cnt_r;
        pressed_nx_s = pressed_r;
        if (level_s == pressed_r) begin
            cnt_nx_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_nx_s     = {CW{1'b0}};
            pressed_nx_s = ~pressed_r;
        end else begin
            cnt_nx_s = cnt_r + CW'(1);
        end
    end

    // Debounce counter and accepted button level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= {CW{1'b0}};
            pressed_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nx_s;
            pressed_r <= pressed_nx_s;
        end
    end

    assign btn_pressed = pressed_r;

endmodule

// File: rtl/reset_gen.sv
// System reset generator: stretches power-on, button and trap resets and
// records the cause of the last reset.
module reset_gen
    import reset_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int STRETCH_CYCLES  = 64,
    parameter int TRAP_RESET      = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_n,
    input  logic       trap,
    output logic       power_on_reset,
    output logic       btn_pressed,
    output logic [1:0] reset_cause
);

    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);
    localparam logic TRAP_ENABLE = (TRAP_RESET != 0);

    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("reset_gen: STRETCH_CYCLES must be at least 1");
    end

    logic          trap_meta_r;
    logic          trap_sync_r;
    logic          trap_prev_r;
    logic          trap_rise_s;
    logic          btn_pressed_s;
    state_t        state_r;
    state_t        state_nx_s;
    logic [SW-1:0] cnt_r;
    logic [SW-1:0] cnt_nx_s;
    cause_t        cause_r;
    cause_t        cause_nx_s;
    logic          por_r;
    logic          por_nx_s;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_n       (btn_n),
        .btn_pressed (btn_pressed_s)
    );

    // Trap synchroniser and previous-sample flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trap_meta_r <= TRAP_IDLE;
            trap_sync_r <= TRAP_IDLE;
            trap_prev_r <= TRAP_IDLE;
        end else begin
            trap_meta_r <= trap;
            trap_sync_r <= trap_meta_r;
            trap_prev_r <= trap_sync_r;
        end
    end

    // Only evaluated in RUN, so an edge seen elsewhere is simply dropped.
    assign trap_rise_s = trap_sync_r & ~trap_prev_r;

    // Next-state, stretch count and cause selection.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        cause_nx_s = cause_r;
        case (state_r)
            STRETCH: begin
                if (btn_pressed_s) begin
                    state_nx_s = HELD;
                    cause_nx_s = CAUSE_BTN;
                end else if (cnt_r == STRETCH_LAST) begin
                    state_nx_s = RUN;
                end else begin
                    cnt_nx_s = cnt_r + SW'(1);
                end
            end
            RUN: begin
                if (btn_pressed_s) begin
                    state_nx_s = HELD;
                    cause_nx_s = CAUSE_BTN;
                end else if (TRAP_ENABLE && trap_rise_s) begin
                    state_nx_s = STRETCH;
                    cause_nx_s = CAUSE_TRAP;
                    cnt_nx_s   = {SW{1'b0}};
                end else begin
                    state_nx_s = RUN;
                end
            end
            HELD: begin
                if (!btn_pressed_s) begin
                    state_nx_s = STRETCH;
                    cnt_nx_s   = {SW{1'b0}};
                end else begin
                    state_nx_s = HELD;
                end
            end
            default: begin
                state_nx_s = STRETCH;
                cnt_nx_s   = {SW{1'b0}};
            end
        endcase
        por_nx_s = state_holds_reset(state_nx_s);
    end

    // State register; the reset output is registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= STRETCH;
            cnt_r   <= {SW{1'b0}};
            cause_r <= CAUSE_POR;
            por_r   <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            cause_r <= cause_nx_s;
            por_r   <= por_nx_s;
        end
    end

    assign power_on_reset = por_r;
    assign btn_pressed    = btn_pressed_s;
    assign reset_cause    = cause_r;

endmodule

// File: tb/tb_reset_gen.sv
// Directed bench for reset_gen with DEBOUNCE_CYCLES=4, STRETCH_CYCLES=3.
// "edge k" means the k-th rising clk edge after the stimulus was applied.
module tb_reset_gen;

    logic       clk;
    logic       reset_n;
    logic       btn_n;
    logic       trap;
    logic       power_on_reset;
    logic       btn_pressed;
    logic [1:0] reset_cause;

    int checks;
    int errors;

    reset_gen #(
        .DEBOUNCE_CYCLES (4),
        .STRETCH_CYCLES  (3),
        .TRAP_RESET      (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .btn_n          (btn_n),
        .trap           (trap),
        .power_on_reset (power_on_reset),
        .btn_pressed    (btn_pressed),
        .reset_cause    (reset_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_n   = 1'b1;
        trap    = 1'b0;
        step(2);
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL rst_por got %b exp 1", power_on_reset); end
        checks++; if (btn_pressed !== 1'b0) begin errors++; $display("FAIL rst_btn got %b exp 0", btn_pressed); end
        checks++; if (reset_cause !== 2'd0) begin errors++; $display("FAIL rst_cause got %0d exp 0", reset_cause); end
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks++;
            if (power_on_reset !== (k < 3 ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL por_release edge %0d got %b exp %b", k, power_on_reset, (k < 3));
            end
        end
        step(2);
        checks++; if (power_on_reset !== 1'b0) begin errors++; $display("FAIL por_run got %b exp 0", power_on_reset); end
        checks++; if (reset_cause !== 2'd0) begin errors++; $display("FAIL por_cause got %0d exp 0", reset_cause); end
    endtask

    task automatic test_clean_press();
        btn_n = 1'b0;
        step(5);
        checks++; if (btn_pressed !== 1'b0) begin errors++; $display("FAIL press_e5 got %b exp 0", btn_pressed); end
        step(1);
        checks++; if (btn_pressed !== 1'b1) begin errors++; $display("FAIL press_e6 got %b exp 1", btn_pressed); end
        checks++; if (power_on_reset !== 1'b0) begin errors++; $display("FAIL press_por_e6 got %b exp 0", power_on_reset); end
        step(1);
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL press_por_e7 got %b exp 1", power_on_reset); end
        checks++; if (reset_cause !== 2'd1) begin errors++; $display("FAIL press_cause got %0d exp 1", reset_cause); end
        step(13);
        btn_n = 1'b1;
        step(5);
        checks++; if (btn_pressed !== 1'b1) begin errors++; $display("FAIL release_e5 got %b exp 1", btn_pressed); end
        step(1);
        checks++; if (btn_pressed !== 1'b0) begin errors++; $display("FAIL release_e6 got %b exp 0", btn_pressed); end
        // HELD exits one edge later, then three STRETCH cycles follow.
        step(3);
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL release_por_hold got %b exp 1", power_on_reset); end
        step(1);
        checks++; if (power_on_reset !== 1'b0) begin errors++; $display("FAIL release_por_fall got %b exp 0", power_on_reset); end
        checks++; if (reset_cause !== 2'd1) begin errors++; $display("FAIL release_cause got %0d exp 1", reset_cause); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            btn_n = 1'b0;
            step(3);
            btn_n = 1'b1;
            step(1);
            checks++; if (btn_pressed !== 1'b0) begin errors++; $display("FAIL bounce_btn iter %0d got %b exp 0", i, btn_pressed); end
            checks++; if (power_on_reset !== 1'b0) begin errors++; $display("FAIL bounce_por iter %0d got %b exp 0", i, power_on_reset); end
        end
        step(6);
        checks++; if (btn_pressed !== 1'b0) begin errors++; $display("FAIL bounce_btn_end got %b exp 0", btn_pressed); end
        checks++; if (power_on_reset !== 1'b0) begin errors++; $display("FAIL bounce_por_end got %b exp 0", power_on_reset); end
    endtask

    task automatic test_trap();
        trap = 1'b1;
        step(1);
        trap = 1'b0;
        step(1);
        checks++; if (power_on_reset !== 1'b0) begin errors++; $display("FAIL trap_e2 got %b exp 0", power_on_reset); end
        step(1);
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL trap_e3 got %b exp 1", power_on_reset); end
        checks++; if (reset_cause !== 2'd2) begin errors++; $display("FAIL trap_cause got %0d exp 2", reset_cause); end
        // Second pulse whose synchronised edge lands inside STRETCH.
        trap = 1'b1;
        step(1);
        trap = 1'b0;
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL trap_e4 got %b exp 1", power_on_reset); end
        step(1);
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL trap_e5 got %b exp 1", power_on_reset); end
        for (int k = 6; k <= 9; k++) begin
            step(1);
            checks++; if (power_on_reset !== 1'b0) begin errors++; $display("FAIL trap_no_ext edge %0d got %b exp 0", k, power_on_reset); end
        end
        checks++; if (reset_cause !== 2'd2) begin errors++; $display("FAIL trap_cause_end got %0d exp 2", reset_cause); end
    endtask

    task automatic test_simultaneous();
        btn_n = 1'b0;
        step(4);
        trap = 1'b1;
        step(1);
        trap = 1'b0;
        step(1);
        checks++; if (btn_pressed !== 1'b1) begin errors++; $display("FAIL sim_btn got %b exp 1", btn_pressed); end
        step(1);
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL sim_por got %b exp 1", power_on_reset); end
        checks++; if (reset_cause !== 2'd1) begin errors++; $display("FAIL sim_cause got %0d exp 1", reset_cause); end
        step(2);
        checks++; if (reset_cause !== 2'd1) begin errors++; $display("FAIL sim_cause_hold got %0d exp 1", reset_cause); end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL mid_por got %b exp 1", power_on_reset); end
        checks++; if (btn_pressed !== 1'b0) begin errors++; $display("FAIL mid_btn got %b exp 0", btn_pressed); end
        checks++; if (reset_cause !== 2'd0) begin errors++; $display("FAIL mid_cause got %0d exp 0", reset_cause); end
        btn_n = 1'b1;
        step(2);
        reset_n = 1'b1;
        step(2);
        checks++; if (power_on_reset !== 1'b1) begin errors++; $display("FAIL mid_rel_e2 got %b exp 1", power_on_reset); end
        step(1);
        checks++; if (power_on_reset !== 1'b0) begin errors++; $display("FAIL mid_rel_e3 got %b exp 0", power_on_reset); end
        checks++; if (btn_pressed !== 1'b0) begin errors++; $display("FAIL mid_rel_btn got %b exp 0", btn_pressed); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_trap();
        test_simultaneous();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
